// File: rtl/bcd_digit_sequencer_if.sv
// ---------------------------------------------------------------------------
// bcd_digit_sequencer_if
//   Bundles the three bus groups of the BCD digit sequencer:
//     - input word handshake : in_valid, in_ready, in_bcd
//     - converter side-band  : dig_out, dig_en, conv_in
//     - result handshake     : out_valid, out_ready, out_data, out_err, err_any
//   slave  : the sequencer's view (it accepts words and produces results).
//   master : the view of whoever feeds words, hosts the converter and
//            consumes results.
// ---------------------------------------------------------------------------
interface bcd_digit_sequencer_if #(
  parameter int NDIG = 4,
  parameter int CW   = 5
);
  logic                 in_valid;
  logic                 in_ready;
  logic [4*NDIG-1:0]    in_bcd;
  logic [3:0]           dig_out;
  logic                 dig_en;
  logic [CW-1:0]        conv_in;
  logic                 out_valid;
  logic                 out_ready;
  logic [CW*NDIG-1:0]   out_data;
  logic [NDIG-1:0]      out_err;
  logic                 err_any;

  modport slave (
    input  in_valid, in_bcd, conv_in, out_ready,
    output in_ready, dig_out, dig_en, out_valid, out_data, out_err, err_any
  );

  modport master (
    output in_valid, in_bcd, conv_in, out_ready,
    input  in_ready, dig_out, dig_en, out_valid, out_data, out_err, err_any
  );
endinterface

// File: rtl/bcd_digit_sequencer.sv
// ---------------------------------------------------------------------------
// bcd_digit_sequencer
//   Time-shares one external combinational BCD digit converter across a
//   packed NDIG-digit BCD word. A word is taken over the in_* handshake,
//   each digit is presented to the converter for two cycles (ISSUE, then
//   CAPTURE) least significant first, the converter result is stored per
//   digit, and the assembled word is returned over the out_* handshake.
//   Digits above 9 are never converted: their field is forced to zero and
//   the matching out_err bit is set.
//
//   Ports:
//     clk  : rising-edge clock
//     rst  : synchronous active-high reset
//     bus  : sequencer view of bcd_digit_sequencer_if (word in, converter
//            side-band, result out)
//     busy : high whenever the sequencer is not IDLE
// ---------------------------------------------------------------------------
module bcd_digit_sequencer #(
  parameter int NDIG = 4,
  parameter int CW   = 5
) (
  input  logic                   clk,
  input  logic                   rst,
  bcd_digit_sequencer_if.slave   bus,
  output logic                   busy
);

  localparam int KW = (NDIG > 1) ? $clog2(NDIG) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, DONE} state_t;

  state_t              state;
  logic [4*NDIG-1:0]   sr;
  logic [KW-1:0]       cnt;
  logic                in_ready_q;
  logic [3:0]          dig_out_q;
  logic                dig_en_q;
  logic                out_valid_q;
  logic [CW*NDIG-1:0]  out_data_q;
  logic [NDIG-1:0]     out_err_q;
  logic                err_any_q;

  // The digit in flight is always the low nibble of the shift register.
  logic [3:0]          cur_dig;
  logic                cur_bad;
  logic [4*NDIG-1:0]   sr_next;

  assign cur_dig = sr[3:0];
  assign cur_bad = (cur_dig > 4'd9);
  assign sr_next = sr >> 4;

  always_ff @(posedge clk) begin
    // NOTE: state is updated with non-blocking assignments so every register
    // sees the pre-edge values; reset is sampled here, making it synchronous.
    if (rst) begin
      state       <= IDLE;
      sr          <= '0;
      cnt         <= '0;
      in_ready_q  <= 1'b1;
      dig_out_q   <= '0;
      dig_en_q    <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_err_q   <= '0;
      err_any_q   <= 1'b0;
      busy        <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid && in_ready_q) begin
            sr          <= bus.in_bcd;
            cnt         <= '0;
            out_data_q  <= '0;
            out_err_q   <= '0;
            err_any_q   <= 1'b0;
            // Present digit 0 straight away so ISSUE already drives it.
            dig_out_q   <= bus.in_bcd[3:0];
            dig_en_q    <= 1'b1;
            in_ready_q  <= 1'b0;
            busy        <= 1'b1;
            state       <= ISSUE;
          end
        end

        ISSUE: begin
          // dig_out is left untouched so the converter settles for a full cycle.
          dig_en_q <= 1'b0;
          state    <= CAPTURE;
        end

        CAPTURE: begin
          if (cur_bad) begin
            out_data_q[int'(cnt)*CW +: CW] <= '0;
            out_err_q[cnt]                 <= 1'b1;
            err_any_q                      <= 1'b1;
          end else begin
            out_data_q[int'(cnt)*CW +: CW] <= bus.conv_in;
          end
          sr  <= sr_next;
          cnt <= cnt + KW'(1);
          if (cnt == KW'(NDIG - 1)) begin
            out_valid_q <= 1'b1;
            state       <= DONE;
          end else begin
            dig_out_q <= sr_next[3:0];
            dig_en_q  <= 1'b1;
            state     <= ISSUE;
          end
        end

        DONE: begin
          if (out_valid_q && bus.out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            busy        <= 1'b0;
            state       <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.dig_out   = dig_out_q;
  assign bus.dig_en    = dig_en_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_err   = out_err_q;
  assign bus.err_any   = err_any_q;

endmodule

// File: tb/tb_bcd_digit_sequencer.sv
// ---------------------------------------------------------------------------
// tb_bcd_digit_sequencer
//   Bench for bcd_digit_sequencer with NDIG=4, CW=5. Hosts a table-lookup
//   converter stub that returns a deliberately bogus code for non-BCD
//   digits, so any use of conv_in for such a digit shows up in out_data.
// ---------------------------------------------------------------------------
module tb_bcd_digit_sequencer;

  localparam int NDIG = 4;
  localparam int CW   = 5;

  logic clk;
  logic rst;
  logic busy;

  int n_tests = 0;
  int n_fail  = 0;

  logic [CW-1:0] conv_tab [16];

  bcd_digit_sequencer_if #(.NDIG(NDIG), .CW(CW)) bus ();

  bcd_digit_sequencer #(.NDIG(NDIG), .CW(CW)) dut (
    .clk  (clk),
    .rst  (rst),
    .bus  (bus),
    .busy (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb bus.conv_in = conv_tab[bus.dig_out];

  typedef struct {
    logic [15:0] bcd;
    logic [19:0] exp_data;
    logic [3:0]  exp_err;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Identity-style converter: BCD digit d -> {0,d}; non-BCD -> garbage.
  task automatic set_identity_tab();
    for (int d = 0; d < 16; d++)
      conv_tab[d] = (d <= 9) ? CW'(d) : 5'h1F;
  endtask

  // Reference: each digit independently, from the table or forced to zero.
  function automatic void model(input logic [15:0] w, output logic [19:0] d,
                                output logic [3:0] e);
    logic [3:0] dig;
    d = '0;
    e = '0;
    for (int k = 0; k < NDIG; k++) begin
      dig = w[4*k +: 4];
      if (dig > 4'd9) e[k] = 1'b1;
      else            d[CW*k +: CW] = conv_tab[dig];
    end
  endfunction

  // Entered at a negedge in the cycle where the word should be accepted.
  // Checks digit order/timing and latency, holds out_ready low for 'hold'
  // cycles after out_valid, and returns at the negedge after the result
  // handshake. With keep_valid, in_valid stays high carrying next_w.
  task automatic run_word(input logic [15:0] w, input int hold, input bit keep_valid,
                          input logic [15:0] next_w, output logic [19:0] data,
                          output logic [3:0] err, output logic eany);
    int         cyc;
    logic [3:0] digs[$];
    int         dcyc[$];
    check("accept_in_ready", bus.in_ready, 1);
    bus.in_bcd    = w;
    bus.in_valid  = 1'b1;
    bus.out_ready = (hold == 0);
    @(negedge clk);
    cyc = 1;
    if (keep_valid) bus.in_bcd = next_w;
    else            bus.in_valid = 1'b0;
    while (!bus.out_valid && cyc < 50) begin
      check("busy_in_ready_low", bus.in_ready, 0);
      if (bus.dig_en) begin
        digs.push_back(bus.dig_out);
        dcyc.push_back(cyc);
      end
      @(negedge clk);
      cyc++;
    end
    check("latency", cyc, 2*NDIG + 1);
    check("digit_count", digs.size(), NDIG);
    for (int i = 0; i < digs.size() && i < NDIG; i++) begin
      check("digit_value", digs[i], w[4*i +: 4]);
      check("digit_cycle", dcyc[i], 1 + 2*i);
    end
    data = bus.out_data;
    err  = bus.out_err;
    eany = bus.err_any;
    for (int i = 0; i < hold; i++) begin
      check("hold_valid", bus.out_valid, 1);
      check("hold_data", bus.out_data, data);
      check("hold_in_ready", bus.in_ready, 0);
      @(negedge clk);
    end
    bus.out_ready = 1'b1;
    check("deliver_valid", bus.out_valid, 1);
    @(negedge clk);
    check("after_valid_low", bus.out_valid, 0);
    check("after_in_ready", bus.in_ready, 1);
  endtask

  vec_t        vecs[6];
  logic [19:0] got_d, exp_d;
  logic [3:0]  got_e, exp_e;
  logic        got_a;
  logic [15:0] w;

  initial begin
    set_identity_tab();
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_bcd    = '0;
    bus.out_ready = 1'b1;

    // Reset state, observed while rst is still asserted.
    @(negedge clk);
    check("rst_in_ready", bus.in_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_dig_en", bus.dig_en, 0);
    check("rst_dig_out", bus.dig_out, 0);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_out_data", bus.out_data, 0);
    check("rst_out_err", bus.out_err, 0);
    check("rst_err_any", bus.err_any, 0);

    // Reset and handshake together: reset wins.
    bus.in_valid = 1'b1;
    bus.in_bcd   = 16'h1234;
    @(negedge clk);
    check("rst_vs_accept_busy", busy, 0);
    check("rst_vs_accept_ready", bus.in_ready, 1);
    rst          = 1'b0;
    bus.in_valid = 1'b0;
    @(negedge clk);

    // Directed vectors with the identity converter.
    vecs[0] = '{16'h1234, {5'd1, 5'd2, 5'd3, 5'd4}, 4'b0000};
    vecs[1] = '{16'h9A04, {5'd9, 5'd0, 5'd0, 5'd4}, 4'b0100};
    vecs[2] = '{16'hFFFF, 20'd0,                    4'b1111};
    vecs[3] = '{16'h0000, 20'd0,                    4'b0000};
    vecs[4] = '{16'h9999, {5'd9, 5'd9, 5'd9, 5'd9}, 4'b0000};
    vecs[5] = '{16'hA009, {5'd0, 5'd0, 5'd0, 5'd9}, 4'b1000};
    for (int i = 0; i < 6; i++) begin
      run_word(vecs[i].bcd, 0, 1'b0, 16'h0, got_d, got_e, got_a);
      check("vec_data", got_d, vecs[i].exp_data);
      check("vec_err", got_e, vecs[i].exp_err);
      check("vec_err_any", got_a, |vecs[i].exp_err);
    end

    // Backpressure for 6 cycles with in_valid held high, then the held word.
    run_word(16'h4321, 6, 1'b1, 16'h0560, got_d, got_e, got_a);
    check("bp_data", got_d, {5'd4, 5'd3, 5'd2, 5'd1});
    run_word(16'h0560, 0, 1'b0, 16'h0, got_d, got_e, got_a);
    check("bp_next_data", got_d, {5'd0, 5'd5, 5'd6, 5'd0});

    // Reset in cycle T+4 of 16'h5678.
    bus.in_bcd   = 16'h5678;
    bus.in_valid = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_busy", busy, 0);
    check("midrst_in_ready", bus.in_ready, 1);
    check("midrst_dig_en", bus.dig_en, 0);
    check("midrst_out_valid", bus.out_valid, 0);
    check("midrst_out_data", bus.out_data, 0);
    run_word(16'h0001, 0, 1'b0, 16'h0, got_d, got_e, got_a);
    check("midrst_fresh_data", got_d, {5'd0, 5'd0, 5'd0, 5'd1});

    // Back-to-back: second word accepted at T+10, result at T+19.
    run_word(16'h1111, 0, 1'b1, 16'h2222, got_d, got_e, got_a);
    check("b2b_first", got_d, {5'd1, 5'd1, 5'd1, 5'd1});
    run_word(16'h2222, 0, 1'b0, 16'h0, got_d, got_e, got_a);
    check("b2b_second", got_d, {5'd2, 5'd2, 5'd2, 5'd2});

    // Randomized words and converter table against the reference model.
    for (int d = 0; d < 10; d++) conv_tab[d] = CW'($urandom_range(0, 31));
    for (int i = 0; i < 40; i++) begin
      w = 16'($urandom);
      model(w, exp_d, exp_e);
      run_word(w, int'($urandom_range(0, 3)), 1'b0, 16'h0, got_d, got_e, got_a);
      check("rnd_data", got_d, exp_d);
      check("rnd_err", got_e, exp_e);
      check("rnd_err_any", got_a, |exp_e);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
